icache: RTL

- Direct-mapped, read-only instruction cache.
- Acts as the responder on the instruction half of the datapath-to-cache interface: it answers imemREN/imemaddr with ihit/imemload.
- On the memory side it is the initiator toward the memory controller, driving iREN/iaddr and consuming iwait/iload.
- Sits between the pipelined datapath fetch stage and the memory controller arbiter.

---
 rtl/icache.sv | 126 ++++++++++++
 1 files changed

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one-word blocks.
// Defining ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t           r_state;
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [31:0]      r_data [SETS];
    logic             r_iren;
    logic [31:0]      r_iaddr;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_miss_idx;
    logic [TAG_W-1:0] w_miss_tag;
    logic             w_hit;
    logic             w_miss;
    logic             w_fill;
    logic             w_unused;

    assign w_idx      = imemaddr[IDX_W+1:2];
    assign w_tag      = imemaddr[31:IDX_W+2];
    assign w_unused   = &{1'b0, imemaddr[1:0]};

    // r_iaddr doubles as the latched miss address; it is only nonzero in FETCH.
    assign w_miss_idx = r_iaddr[IDX_W+1:2];
    assign w_miss_tag = r_iaddr[31:IDX_W+2];

    assign w_hit  = (r_state == IDLE) && imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss = (r_state == IDLE) && imemREN && !w_hit;
    assign w_fill = (r_state == FETCH) && !iwait;

    assign ihit     = w_hit;
    assign imemload = w_hit ? r_data[w_idx] : 32'd0;
    assign iREN     = r_iren;
    assign iaddr    = r_iaddr;

    // Control FSM, valid bits and the memory-side request registers.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_valid <= '0;
            r_iren  <= 1'b0;
            r_iaddr <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_state <= FETCH;
                        r_iren  <= 1'b1;
                        r_iaddr <= {imemaddr[31:2], 2'b00};
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        r_state             <= IDLE;
                        r_iren              <= 1'b0;
                        r_iaddr             <= 32'd0;
                        r_valid[w_miss_idx] <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_iren  <= 1'b0;
                    r_iaddr <= 32'd0;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; a reset during FETCH suppresses the write.
    always_ff @(posedge CLK) begin
        if (nRST && w_fill) begin
            r_tag[w_miss_idx]  <= w_miss_tag;
            r_data[w_miss_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule
